// File: rtl/rtf65002_ibuf.sv
// Instruction prefetch byte queue: fetches aligned words over a Wishbone-style port and presents 8 bytes at PC.
// Optional RTF65002_IBUF_PERF_EN adds starve_cnt_o (cycles decode wanted bytes while the queue was not ready).
module rtf65002_ibuf #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAXLEN     = 7,
  parameter logic [31:0] RESET_ADDR = 32'hFFFFFFF0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        consume_i,
  input  logic [3:0]  cnt_i,
  output logic        rdy_o,
  output logic [31:0] pc_o,
  output logic [63:0] ibytes_o,
  output logic [4:0]  level_o
`ifdef RTF65002_IBUF_PERF_EN
  ,
  output logic [31:0] starve_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     fadr_q, fadr_d;
  logic [31:0]     adr_q, adr_d;
  logic [1:0]      skip_q, skip_d;
  logic            rdy_q, rdy_d;
  logic [7:0]      mem_q [DEPTH];

  logic            take;
  logic            accept;
  logic [2:0]      nbytes;
  logic [31:0]     dat_sh;

  always_comb begin
    take    = (state_q == FETCH) && ack_i && !flush_i;
    accept  = consume_i && rdy_q && (32'(cnt_i) <= MAXLEN);
    nbytes  = 3'd4 - {1'b0, skip_q};
    dat_sh  = dat_i >> {skip_q, 3'b000};

    level_d = level_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pc_d    = pc_q;
    fadr_d  = fadr_q;
    skip_d  = skip_q;

    if (flush_i) begin
      level_d = '0;
      head_d  = tail_q;
      pc_d    = flush_pc_i;
      fadr_d  = {flush_pc_i[31:2], 2'b00};
      skip_d  = flush_pc_i[1:0];
    end else begin
      if (take) begin
        tail_d = tail_q + AW'(nbytes);
        fadr_d = fadr_q + 32'd4;
        skip_d = '0;
      end
      if (accept) begin
        head_d = head_q + AW'(cnt_i);
        pc_d   = pc_q + 32'(cnt_i);
      end
      level_d = level_q + (take ? LW'(nbytes) : '0) - (accept ? LW'(cnt_i) : '0);
    end
    rdy_d = (32'(level_d) >= MAXLEN);

    state_d = state_q;
    case (state_q)
      IDLE:  if (!flush_i && (DEPTH - 32'(level_q)) >= 32'd4) state_d = FETCH;
      FETCH: begin
        if (flush_i)    state_d = ack_i ? IDLE : DRAIN;
        else if (ack_i) state_d = ((DEPTH - 32'(level_d)) >= 32'd4) ? FETCH : IDLE;
      end
      DRAIN: if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The bus address is frozen while a cycle is outstanding (including a drain);
    // otherwise it tracks the fetch pointer so a new cycle starts at the right word.
    adr_d = ((state_q != IDLE) && !ack_i) ? adr_q : fadr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      level_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      pc_q    <= RESET_ADDR;
      fadr_q  <= {RESET_ADDR[31:2], 2'b00};
      adr_q   <= {RESET_ADDR[31:2], 2'b00};
      skip_q  <= RESET_ADDR[1:0];
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      pc_q    <= pc_d;
      fadr_q  <= fadr_d;
      adr_q   <= adr_d;
      skip_q  <= skip_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (take) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (i < 32'(nbytes)) mem_q[tail_q + AW'(i)] <= dat_sh[8*i +: 8];
      end
    end
  end

  always_comb begin
    ibytes_o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      ibytes_o[8*i +: 8] = mem_q[head_q + AW'(i)];
    end
  end

  assign cyc_o   = (state_q != IDLE);
  assign stb_o   = cyc_o;
  assign adr_o   = adr_q;
  assign pc_o    = pc_q;
  assign rdy_o   = rdy_q;
  assign level_o = 5'(level_q);

`ifdef RTF65002_IBUF_PERF_EN
  logic [31:0] starve_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (consume_i && !rdy_q && (starve_q != '1)) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign starve_cnt_o = starve_q;
`endif

endmodule

// File: tb/tb_rtf65002_ibuf.sv
// Self-checking bench for rtf65002_ibuf: directed scenarios plus randomized traffic against a byte-queue model.
module tb_rtf65002_ibuf;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MAXLEN = 7;
  localparam logic [31:0] RA     = 32'h100;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cyc_o, stb_o;
  logic [31:0] adr_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        consume_i;
  logic [3:0]  cnt_i;
  logic        rdy_o;
  logic [31:0] pc_o;
  logic [63:0] ibytes_o;
  logic [4:0]  level_o;
`ifdef RTF65002_IBUF_PERF_EN
  logic [31:0] starve_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  int          ack_delay = 1;
  logic        resp_en   = 1'b1;

  // model state
  logic [7:0]  mq[$];
  logic [31:0] m_pc   = RA;
  logic [31:0] m_fa   = RA;
  logic        m_drain = 1'b0;
  logic [31:0] m_starve = '0;
  int          m_adr_bad = 0;

  rtf65002_ibuf #(
    .DEPTH(DEPTH),
    .MAXLEN(MAXLEN),
    .RESET_ADDR(RA)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .cyc_o(cyc_o),
    .stb_o(stb_o),
    .adr_o(adr_o),
    .dat_i(dat_i),
    .ack_i(ack_i),
    .flush_i(flush_i),
    .flush_pc_i(flush_pc_i),
    .consume_i(consume_i),
    .cnt_i(cnt_i),
    .rdy_o(rdy_o),
    .pc_o(pc_o),
    .ibytes_o(ibytes_o),
    .level_o(level_o)
`ifdef RTF65002_IBUF_PERF_EN
    ,
    .starve_cnt_o(starve_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'(a + 32'd3), 8'(a + 32'd2), 8'(a + 32'd1), 8'(a)};
  endfunction

  // Bus slave: memory byte n holds n[7:0]; ack after ack_delay waited cycles.
  initial begin
    int wcnt;
    wcnt  = 0;
    ack_i = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (cyc_o === 1'b1 && resp_en && wcnt >= ack_delay) begin
        ack_i = 1'b1;
        dat_i = mem_word(adr_o);
        wcnt  = 0;
      end else begin
        ack_i = 1'b0;
        if (cyc_o === 1'b1) wcnt++;
        else wcnt = 0;
      end
    end
  end

  // Reference model: a byte queue fed by accepted acks, drained by accepted consumes.
  initial begin
    logic acc, cons;
    int   n;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        mq.delete();
        m_pc     = RA;
        m_fa     = RA;
        m_drain  = 1'b0;
        m_starve = '0;
      end else begin
        acc  = cyc_o && ack_i;
        cons = consume_i && (mq.size() >= int'(MAXLEN)) && (32'(cnt_i) <= MAXLEN);
        if (consume_i && mq.size() < int'(MAXLEN) && m_starve != '1) m_starve++;
        if (flush_i) begin
          m_drain = cyc_o && !ack_i;
          mq.delete();
          m_pc = flush_pc_i;
          m_fa = flush_pc_i;
        end else begin
          if (acc) begin
            if (m_drain) begin
              m_drain = 1'b0;
            end else begin
              if (adr_o != {m_fa[31:2], 2'b00}) m_adr_bad++;
              n = 4 - int'(m_fa[1:0]);
              for (int k = 0; k < n; k++) mq.push_back(8'(m_fa + 32'(k)));
              m_fa = {m_fa[31:2], 2'b00} + 32'd4;
            end
          end
          if (cons) begin
            for (int k = 0; k < int'(cnt_i); k++) void'(mq.pop_front());
            m_pc = m_pc + 32'(cnt_i);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    flush_i = 1'b0; flush_pc_i = '0; consume_i = 1'b0; cnt_i = '0;
    resp_en = 1'b1; ack_delay = 1;
    rst_ni = 1'b0;
    tick();
    tick();
    checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got cyc=%b stb=%b expected 0 0", cyc_o, stb_o); end
    checks++; if (adr_o !== 32'h100) begin errors++; $display("FAIL reset_adr: got %h expected %h", adr_o, 32'h100); end
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h100); end
    checks++; if (level_o !== 5'd0 || rdy_o !== 1'b0) begin errors++; $display("FAIL reset_level: got level=%0d rdy=%b expected 0 0", level_o, rdy_o); end
  endtask

  task automatic test_startup();
    logic [31:0] adrs[$];
    rst_ni = 1'b1;
    for (int n = 0; n < 50 && rdy_o !== 1'b1; n++) begin
      if (ack_i === 1'b1) adrs.push_back(adr_o);
      tick();
    end
    checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL startup_rdy_timeout: got rdy=%b expected 1", rdy_o); end
    checks++; if (adrs.size() < 2 || adrs[0] !== 32'h100 || adrs[1] !== 32'h104) begin
      errors++; $display("FAIL startup_adr: got %0d acks first=%h second=%h expected 100 104",
                         adrs.size(), (adrs.size() > 0) ? adrs[0] : 32'hx, (adrs.size() > 1) ? adrs[1] : 32'hx);
    end
    checks++; if (level_o !== 5'd8) begin errors++; $display("FAIL startup_level: got %0d expected 8", level_o); end
    checks++; if (ibytes_o !== 64'h0706050403020100) begin errors++; $display("FAIL startup_ibytes: got %h expected %h", ibytes_o, 64'h0706050403020100); end
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL startup_pc: got %h expected 100", pc_o); end
  endtask

  task automatic test_consume();
    logic       was_ack;
    logic [4:0] exp_level;
    was_ack   = ack_i;
    consume_i = 1'b1; cnt_i = 4'd3;
    tick();
    consume_i = 1'b0;
    exp_level = was_ack ? 5'd9 : 5'd5;
    checks++; if (pc_o !== 32'h103) begin errors++; $display("FAIL consume_pc: got %h expected 103", pc_o); end
    checks++; if (ibytes_o[7:0] !== 8'h03) begin errors++; $display("FAIL consume_opcode: got %h expected 03", ibytes_o[7:0]); end
    checks++; if (level_o !== exp_level) begin errors++; $display("FAIL consume_level: got %0d expected %0d", level_o, exp_level); end
  endtask

  task automatic test_flush();
    flush_i = 1'b1; flush_pc_i = 32'h205;
    tick();
    flush_i = 1'b0;
    checks++; if (level_o !== 5'd0 || pc_o !== 32'h205) begin errors++; $display("FAIL flush_state: got level=%0d pc=%h expected 0 205", level_o, pc_o); end
    for (int n = 0; n < 20 && cyc_o !== 1'b0; n++) tick();
    for (int n = 0; n < 20 && cyc_o !== 1'b1; n++) tick();
    checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h204) begin errors++; $display("FAIL flush_adr: got cyc=%b adr=%h expected 1 204", cyc_o, adr_o); end
    for (int n = 0; n < 20 && level_o === 5'd0; n++) tick();
    checks++; if (level_o !== 5'd3) begin errors++; $display("FAIL flush_first_ack: got level %0d expected 3", level_o); end
    for (int n = 0; n < 20 && level_o === 5'd3; n++) tick();
    checks++; if (level_o !== 5'd7 || rdy_o !== 1'b1) begin errors++; $display("FAIL flush_second_ack: got level=%0d rdy=%b expected 7 1", level_o, rdy_o); end
    checks++; if (ibytes_o[55:0] !== 56'h0B0A0908070605) begin errors++; $display("FAIL flush_ibytes: got %h expected 0b0a0908070605", ibytes_o[55:0]); end
  endtask

  task automatic test_drain();
    ack_delay = 0;
    do_reset();
    for (int n = 0; n < 20 && level_o !== 5'd4; n++) tick();
    ack_delay = 3;
    tick();
    checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h108 || level_o !== 5'd8) begin
      errors++; $display("FAIL drain_setup: got cyc=%b adr=%h level=%0d expected 1 108 8", cyc_o, adr_o, level_o);
    end
    flush_i = 1'b1; flush_pc_i = 32'h300;
    tick();
    flush_i = 1'b0;
    for (int n = 0; n < 10 && ack_i !== 1'b1; n++) begin
      checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h108) begin errors++; $display("FAIL drain_hold: got cyc=%b adr=%h expected 1 108", cyc_o, adr_o); end
      tick();
    end
    checks++; if (ack_i !== 1'b1) begin errors++; $display("FAIL drain_ack_timeout: got ack=%b expected 1", ack_i); end
    ack_delay = 1;
    tick();
    checks++; if (cyc_o !== 1'b0 || level_o !== 5'd0) begin errors++; $display("FAIL drain_end: got cyc=%b level=%0d expected 0 0", cyc_o, level_o); end
    tick();
    checks++; if (cyc_o !== 1'b1 || adr_o !== 32'h300) begin errors++; $display("FAIL drain_refetch: got cyc=%b adr=%h expected 1 300", cyc_o, adr_o); end
  endtask

  task automatic test_full();
    ack_delay = 0;
    do_reset();
    for (int n = 0; n < 40 && level_o !== 5'd16; n++) tick();
    checks++; if (level_o !== 5'd16 || cyc_o !== 1'b0) begin errors++; $display("FAIL full_stop: got level=%0d cyc=%b expected 16 0", level_o, cyc_o); end
    tick(); tick(); tick();
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL full_idle: got cyc=%b expected 0", cyc_o); end
    consume_i = 1'b1; cnt_i = 4'd7;
    tick();
    consume_i = 1'b0;
    checks++; if (level_o !== 5'd9 || pc_o !== 32'h107) begin errors++; $display("FAIL full_consume: got level=%0d pc=%h expected 9 107", level_o, pc_o); end
    for (int n = 0; n < 20 && level_o !== 5'd13; n++) tick();
    checks++; if (level_o !== 5'd13) begin errors++; $display("FAIL full_refill: got level %0d expected 13", level_o); end
    for (int n = 0; n < 10; n++) tick();
    checks++; if (cyc_o !== 1'b0 || level_o !== 5'd13) begin errors++; $display("FAIL full_room3: got cyc=%b level=%0d expected 0 13", cyc_o, level_o); end
  endtask

  task automatic test_ack_consume();
    logic hit;
    hit = 1'b0;
    ack_delay = 2;
    consume_i = 1'b1; cnt_i = 4'd4;
    tick();
    consume_i = 1'b0;
    checks++; if (level_o !== 5'd9) begin errors++; $display("FAIL ackcons_pre: got level %0d expected 9", level_o); end
    for (int n = 0; n < 20 && !hit; n++) begin
      if (ack_i === 1'b1) begin
        hit = 1'b1;
        consume_i = 1'b1; cnt_i = 4'd5;
        resp_en = 1'b0;
      end
      tick();
    end
    consume_i = 1'b0;
    checks++; if (level_o !== 5'd8 || pc_o !== 32'h110) begin errors++; $display("FAIL ackcons_level: got level=%0d pc=%h expected 8 110", level_o, pc_o); end
    consume_i = 1'b1; cnt_i = 4'd8;
    tick();
    consume_i = 1'b0;
    checks++; if (level_o !== 5'd8 || pc_o !== 32'h110) begin errors++; $display("FAIL cnt8_ignored: got level=%0d pc=%h expected 8 110", level_o, pc_o); end
    checks++; if (ibytes_o[7:0] !== 8'h10) begin errors++; $display("FAIL cnt8_opcode: got %h expected 10", ibytes_o[7:0]); end
  endtask

  task automatic test_reset_midcycle();
    tick();
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (cyc_o !== 1'b0 || level_o !== 5'd0 || adr_o !== 32'h100) begin
      errors++; $display("FAIL reset_midcycle: got cyc=%b level=%0d adr=%h expected 0 0 100", cyc_o, level_o, adr_o);
    end
    tick();
    rst_ni  = 1'b1;
    resp_en = 1'b1;
  endtask

`ifdef RTF65002_IBUF_PERF_EN
  task automatic test_perf();
    resp_en = 1'b0;
    do_reset();
    consume_i = 1'b1; cnt_i = 4'd1;
    for (int n = 0; n < 4; n++) tick();
    consume_i = 1'b0;
    tick();
    checks++; if (starve_cnt_o !== 32'd4) begin errors++; $display("FAIL starve_count: got %0d expected 4", starve_cnt_o); end
    flush_i = 1'b1; flush_pc_i = 32'h400;
    tick();
    flush_i = 1'b0;
    checks++; if (starve_cnt_o !== 32'd4) begin errors++; $display("FAIL starve_flush: got %0d expected 4", starve_cnt_o); end
    resp_en = 1'b1;
  endtask
`endif

  task automatic test_random();
    logic        prev_cyc, prev_ack;
    logic [31:0] prev_adr;
    logic [63:0] exp_b, mask;
    ack_delay = 1;
    resp_en   = 1'b1;
    do_reset();
    prev_cyc = 1'b0; prev_ack = 1'b0; prev_adr = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      exp_b = '0; mask = '0;
      for (int i = 0; i < 8 && i < mq.size(); i++) begin
        exp_b[8*i +: 8] = mq[i];
        mask[8*i +: 8]  = 8'hFF;
      end
      checks++; if (level_o !== 5'(mq.size())) begin errors++; $display("FAIL rnd_level @%0d: got %0d expected %0d", cyc, level_o, mq.size()); end
      checks++; if (pc_o !== m_pc) begin errors++; $display("FAIL rnd_pc @%0d: got %h expected %h", cyc, pc_o, m_pc); end
      checks++; if (rdy_o !== (mq.size() >= int'(MAXLEN))) begin errors++; $display("FAIL rnd_rdy @%0d: got %b expected %b", cyc, rdy_o, mq.size() >= int'(MAXLEN)); end
      checks++; if ((ibytes_o & mask) !== exp_b) begin errors++; $display("FAIL rnd_ibytes @%0d: got %h expected %h mask %h", cyc, ibytes_o & mask, exp_b, mask); end
      checks++; if (stb_o !== cyc_o || adr_o[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_bus @%0d: got stb=%b cyc=%b adr=%h expected stb==cyc, aligned", cyc, stb_o, cyc_o, adr_o); end
      if (prev_cyc && !prev_ack) begin
        checks++; if (cyc_o !== 1'b1 || adr_o !== prev_adr) begin errors++; $display("FAIL rnd_hold @%0d: got cyc=%b adr=%h expected 1 %h", cyc, cyc_o, adr_o, prev_adr); end
      end
      prev_cyc = cyc_o; prev_ack = ack_i; prev_adr = adr_o;
      if (cyc % 50 == 0) ack_delay = int'($urandom_range(0, 3));
      flush_i    = ($urandom_range(0, 29) == 0);
      flush_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7))) : $urandom;
      consume_i  = 1'($urandom_range(0, 1));
      cnt_i      = 4'($urandom_range(0, 8));
    end
    flush_i = 1'b0; consume_i = 1'b0;
    checks++; if (m_adr_bad !== 0) begin errors++; $display("FAIL rnd_fetch_adr: got %0d wrong fetch addresses expected 0", m_adr_bad); end
`ifdef RTF65002_IBUF_PERF_EN
    tick();
    checks++; if (starve_cnt_o !== m_starve) begin errors++; $display("FAIL rnd_starve: got %0d expected %0d", starve_cnt_o, m_starve); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0; flush_pc_i = '0; consume_i = 1'b0; cnt_i = '0;
    test_reset();
    test_startup();
    test_consume();
    test_flush();
    test_drain();
    test_full();
    test_ack_consume();
    test_reset_midcycle();
`ifdef RTF65002_IBUF_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtf65002_ibuf.md
Name: rtf65002_ibuf

Overview:
- Instruction prefetch byte queue for the rtf65002 core.
- Fetches aligned 32-bit words over a Wishbone-style read port and buffers them as bytes.
- Presents the next 8 bytes at the current PC to decode, with byte 0 as the opcode byte. This is the byte that feeds the PC-increment table.
- Retires the number of bytes that table reports when decode signals consume; redirects on flush.

Parameters:
- DEPTH, 16: queue depth in bytes. Must be a power of two and at least 12.
- MAXLEN, 7: longest instruction in bytes. It is the rdy_o threshold.
- RESET_ADDR, 32'hFFFFFFF0: byte address fetched first after reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cyc_o  out  1  bus cycle active
- stb_o  out  1  strobe; identical to cyc_o
- adr_o  out  32  fetch address; bits [1:0] always 0
- dat_i  in  32  fetch data, little-endian
- ack_i  in  1  fetch acknowledge
- flush_i  in  1  redirect request
- flush_pc_i  in  32  redirect byte address
- consume_i  in  1  decode retires an instruction
- cnt_i  in  4  bytes retired, taken from the PC-increment output
- rdy_o  out  1  queue holds at least MAXLEN bytes
- pc_o  out  32  byte address of queue head
- ibytes_o  out  64  bytes head..head+7; byte 0 is [7:0]
- level_o  out  5  bytes currently queued, 0..DEPTH

Behaviour:
- Reset (asynchronous, rst_ni low):
  - level=0, head=tail=0, state=IDLE, cyc_o=stb_o=0.
  - adr_o=RESET_ADDR&~3, pc_o=RESET_ADDR, skip=RESET_ADDR[1:0], rdy_o=0.
  - Reset asserted mid bus cycle drops cyc_o immediately; the ack is never awaited.
- State machine:
  - IDLE→FETCH when not flush_i and DEPTH−level ≥ 4. Assert cyc_o/stb_o on the next edge with the current fetch address.
  - FETCH: hold cyc_o/stb_o/adr_o stable until ack_i.
    - On ack without flush: write bytes dat_i[8*skip +: 8*(4−skip)] at tail, tail+=4−skip, level+=4−skip, skip=0, fetch address+=4.
    - Then go to FETCH again if there is still room after the update, else IDLE. Back-to-back fetches are permitted.
  - DRAIN: entered when flush_i is seen in FETCH with no ack that cycle. Keep cyc_o high until ack_i, discard the data, then go to IDLE.
- Flush (highest priority):
  - Same edge: level=0, head=tail, pc_o=flush_pc_i, fetch address=flush_pc_i&~3, skip=flush_pc_i[1:0].
  - Any ack or consume in that same cycle is ignored.
  - If flush and ack coincide in FETCH, the data is dropped and the block goes to IDLE.
- rdy_o = (level ≥ MAXLEN), registered consistently with level.
- ibytes_o:
  - Combinational read of the 8 entries from head, wrapping modulo DEPTH.
  - Bytes at positions ≥ level are don't-care.
- Consume:
  - Accepted only when consume_i && rdy_o && cnt_i ≤ MAXLEN. head+=cnt_i, pc_o+=cnt_i, level−=cnt_i.
  - cnt_i=0 is a no-op. Otherwise it is ignored, with no state change.
- Simultaneous ack and consume: level_next = level + (4−skip) − cnt_i.
- Pointer wrap: head and tail are log2(DEPTH)-bit and wrap silently. level alone distinguishes full from empty.
- Invariants:
  - level never exceeds DEPTH.
  - At most one outstanding bus cycle.
  - pc_o wraps modulo 2^32.

Optional Feature:
- RTF65002_IBUF_PERF_EN defined: adds output starve_cnt_o[31:0].
  - Counts cycles where consume_i=1 and rdy_o=0.
  - Reset to 0, saturates at 32'hFFFFFFFF, not cleared by flush.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset with RESET_ADDR=32'h100, memory byte n = n[7:0], ack 1 cycle after stb: first adr_o=0x100, second 0x104. rdy_o rises after the second ack with level=8, ibytes_o=64'h0706050403020100, pc_o=0x100.
- Then consume_i=1, cnt_i=3: next cycle pc_o=0x103, ibytes_o[7:0]=0x03, level=5+4 if an ack coincides, else 5.
- flush_i with flush_pc_i=0x205: adr_o=0x204. The first ack adds 3 bytes (level=3). After the next ack level=7, rdy_o=1, ibytes_o[7:0]=0x05.
- flush_i at 0x300 while a fetch to 0x108 is pending, ack delayed 3 cycles: cyc_o stays high until ack, no bytes enter the queue, and the next adr_o=0x300.
- Never consume: fetching stops with level=16, cyc_o=0. Consume cnt_i=7: level=9, then a fetch restarts, giving level=13. With no further consumes the next fetch is not issued (room 3 < 4).
- level=9, consume cnt_i=5 in the same cycle as an aligned ack: level=8. Then cnt_i=8 with MAXLEN=7: ignored, level and pc_o unchanged. Also with RTF65002_IBUF_PERF_EN: consume_i held 4 cycles while rdy_o=0 → starve_cnt_o=4.
